// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : icache_assoc
// Purpose  : Set-associative, multi-word-block instruction cache sitting
//            between the datapath fetch port and the memory controller's
//            instruction channel. Hits answer combinationally. Misses run a
//            sequential block fill. Replacement is LRU when WAYS=2.
// Ports    : CLK, nRST                  - clock, async active-low reset
//            halt, imemREN, imemaddr    - fetch request side
//            dmemREN, dmemWEN           - data access pending (blocks lookup)
//            iflush                     - invalidate every line
//            ihit, imemload             - fetch result
//            iREN, iaddr, iwait, iload  - memory instruction channel
//            hit_count, miss_count      - wrapping performance counters
// Revision : 1.0 - initial release
// ============================================================================
module icache_assoc #(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2,
  parameter int CNTW  = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            halt,
  input  logic            imemREN,
  input  logic [31:0]     imemaddr,
  input  logic            dmemREN,
  input  logic            dmemWEN,
  input  logic            iflush,
  output logic            ihit,
  output logic [31:0]     imemload,
  output logic            iREN,
  output logic [31:0]     iaddr,
  input  logic            iwait,
  input  logic [31:0]     iload,
  output logic [CNTW-1:0] hit_count,
  output logic [CNTW-1:0] miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int OB = $clog2(WORDS);          // word-offset bits (0 when WORDS=1)
  localparam int KW = (OB > 0) ? OB : 1;      // fill counter width
  localparam int TW = 30 - OB - IW;           // tag width

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      base_q;
  logic             victim_q;
  logic [KW-1:0]    k_q;
  logic             flush_pend_q;
  logic [CNTW-1:0]  hit_cnt_q, miss_cnt_q;
  logic [SETS-1:0]  lru_q;                    // per set: way to evict next

  logic             valid_q [WAYS][SETS];
  logic [TW-1:0]    tag_q   [WAYS][SETS];
  logic [31:0]      data_q  [WAYS][SETS][WORDS];

  // Address fields of the incoming fetch and of the block being filled.
  // Shifts instead of slices keep WORDS=1 free of zero-width ranges.
  logic [IW-1:0]    w_idx, w_fidx;
  logic [KW-1:0]    w_word;
  logic [TW-1:0]    w_tag, w_ftag;
  assign w_idx  = IW'(imemaddr >> (2 + OB));
  assign w_word = KW'((imemaddr >> 2) & 32'(WORDS - 1));
  assign w_tag  = TW'(imemaddr >> (2 + OB + IW));
  assign w_fidx = IW'(base_q >> (2 + OB));
  assign w_ftag = TW'(base_q >> (2 + OB + IW));

  logic             w_lookup, w_any, w_hit, w_miss, w_last, w_hitw, w_victim;
  logic [31:0]      w_hit_data;

  assign w_lookup = (state_q == ST_IDLE) && imemREN && !halt && !dmemREN && !dmemWEN;

  always_comb begin
    w_any      = 1'b0;
    w_hitw     = 1'b0;
    w_hit_data = 32'h0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][w_idx] && (tag_q[w][w_idx] == w_tag)) begin
        w_any      = 1'b1;
        w_hitw     = 1'(w);
        w_hit_data = data_q[w][w_idx][w_word];
      end
    end
  end

  assign w_hit  = w_lookup && w_any;
  assign w_miss = w_lookup && !w_any;
  assign w_last = (state_q == ST_FILL) && !iwait && (k_q == KW'(WORDS - 1));

  // Victim: an invalid way first (way 0 preferred), otherwise the LRU way.
  always_comb begin
    w_victim = 1'b0;
    if (WAYS > 1 && valid_q[0][w_idx]) begin
      if (!valid_q[WAYS-1][w_idx]) w_victim = 1'b1;
      else                         w_victim = lru_q[w_idx];
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_miss) state_d = ST_FILL;
      ST_FILL: if (w_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    iREN     = (state_q == ST_FILL);
    iaddr    = (state_q == ST_FILL) ? (base_q + (32'(k_q) << 2)) : 32'h0;
    ihit     = w_hit;
    imemload = w_hit ? w_hit_data : 32'h0;
  end

  // Control state, valid bits, LRU and counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      base_q       <= 32'h0;
      victim_q     <= 1'b0;
      k_q          <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      lru_q        <= '0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++)
          valid_q[w][s] <= 1'b0;
    end else begin
      if (w_hit) begin
        lru_q[w_idx] <= ~w_hitw;
        hit_cnt_q    <= hit_cnt_q + CNTW'(1);
      end
      if (w_miss) begin
        base_q     <= imemaddr & ~(32'(WORDS * 4) - 32'd1);
        victim_q   <= w_victim;
        k_q        <= '0;
        miss_cnt_q <= miss_cnt_q + CNTW'(1);
      end
      // A lookup in the same cycle already used the pre-flush valid bits.
      if (state_q == ST_IDLE && iflush) begin
        for (int w = 0; w < WAYS; w++)
          for (int s = 0; s < SETS; s++)
            valid_q[w][s] <= 1'b0;
      end
      if (state_q == ST_FILL) begin
        if (iflush) flush_pend_q <= 1'b1;
        if (!iwait) k_q <= k_q + KW'(1);
        if (w_last) begin
          flush_pend_q     <= 1'b0;
          lru_q[w_fidx]    <= ~victim_q;
          // A flush seen anywhere in the fill also kills the new line.
          if (flush_pend_q || iflush) begin
            for (int w = 0; w < WAYS; w++)
              for (int s = 0; s < SETS; s++)
                valid_q[w][s] <= 1'b0;
          end else begin
            valid_q[victim_q][w_fidx] <= 1'b1;
          end
        end
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge CLK) begin
    if (state_q == ST_FILL && !iwait) data_q[victim_q][w_fidx][k_q] <= iload;
    if (w_last)                       tag_q[victim_q][w_fidx]       <= w_ftag;
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_assoc
// Purpose  : Directed self-checking bench for icache_assoc (SETS=8, WAYS=2,
//            WORDS=2). Inputs change on the falling edge, outputs are sampled
//            1 ns later, away from the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_assoc;

  logic        CLK = 1'b0;
  logic        nRST, halt, imemREN, dmemREN, dmemWEN, iflush, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr;
  logic [31:0] hit_count, miss_count;

  int errors = 0;
  int checks = 0;

  // Observations recorded by the stimulus helpers
  logic        r_miss_hit, r_post_hit, r_post_ren, r_hit;
  logic [31:0] r_post_load, r_load;
  int          r_ren_cycles, r_addr_bad, r_hit_during;

  icache_assoc #(.SETS(8), .WAYS(2), .WORDS(2), .CNTW(32)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt), .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .iflush(iflush), .ihit(ihit),
    .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Stimulus only: present a missing fetch, serve both beats (each preceded
  // by nwait wait cycles with junk on iload), then optionally re-present it.
  task automatic do_fill(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1,
                         input int nwait, input bit present_after, input bit flush_beat0);
    logic [31:0] base;
    base = {a[31:3], 3'b000};
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = a; iwait = 1'b0; iflush = 1'b0;
    #1 r_miss_hit = ihit;
    r_ren_cycles = 0; r_addr_bad = 0; r_hit_during = 0;
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w <= nwait; w++) begin
        @(negedge CLK);
        iwait  = (w < nwait);
        iload  = (w < nwait) ? (32'hBAD0_0000 | 32'(w)) : ((b == 0) ? d0 : d1);
        iflush = flush_beat0 && (b == 0) && (w == 0);
        #1;
        if (iREN) r_ren_cycles++;
        if (iaddr !== base + 32'(4 * b)) r_addr_bad++;
        if (ihit) r_hit_during++;
      end
    end
    @(negedge CLK);
    iflush = 1'b0; iwait = 1'b0; iload = 32'hDEAD_BEEF; imemREN = present_after;
    #1 r_post_hit = ihit; r_post_load = imemload; r_post_ren = iREN;
  endtask

  task automatic lookup(input logic [31:0] a);
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = a;
    #1 r_hit = ihit; r_load = imemload;
  endtask

  task automatic idle();
    @(negedge CLK);
    imemREN = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; halt = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; dmemREN = 1'b0;
    dmemWEN = 1'b0; iflush = 1'b0; iwait = 1'b0; iload = 32'h0;
    @(negedge CLK); #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit: got %h want 0", ihit); end
    checks++; if (imemload !== 32'h0) begin errors++; $display("FAIL reset_imemload: got %h want 0", imemload); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_iREN: got %h want 0", iREN); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %h want 0", iaddr); end
    checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin errors++;
      $display("FAIL reset_counters: got hit=%0d miss=%0d want 0/0", hit_count, miss_count); end
    @(negedge CLK); nRST = 1'b1; imemREN = 1'b0;
  endtask

  task automatic test_cold_miss();
    do_fill(32'h40, 32'hAAAA_0001, 32'hAAAA_0002, 0, 1'b1, 1'b0);
    checks++; if (r_miss_hit !== 1'b0) begin errors++; $display("FAIL cold_miss_ihit: got %h want 0", r_miss_hit); end
    checks++; if (r_ren_cycles != 2) begin errors++; $display("FAIL cold_iren_cycles: got %0d want 2", r_ren_cycles); end
    checks++; if (r_addr_bad != 0) begin errors++; $display("FAIL cold_iaddr_seq: got %0d bad want 0", r_addr_bad); end
    checks++; if (r_post_hit !== 1'b1 || r_post_load !== 32'hAAAA_0001) begin errors++;
      $display("FAIL cold_refetch: got hit=%h data=%h want 1/aaaa0001", r_post_hit, r_post_load); end
    checks++; if (r_post_ren !== 1'b0) begin errors++; $display("FAIL cold_iren_drop: got %h want 0", r_post_ren); end
    lookup(32'h44);
    checks++; if (r_hit !== 1'b1 || r_load !== 32'hAAAA_0002) begin errors++;
      $display("FAIL cold_word1: got hit=%h data=%h want 1/aaaa0002", r_hit, r_load); end
    idle();
    checks++; if (hit_count !== 32'd2 || miss_count !== 32'd1) begin errors++;
      $display("FAIL cold_counters: got hit=%0d miss=%0d want 2/1", hit_count, miss_count); end
  endtask

  task automatic test_lru();
    do_fill(32'h440, 32'hBBBB_0001, 32'hBBBB_0002, 0, 1'b1, 1'b0);
    checks++; if (r_miss_hit !== 1'b0 || r_post_load !== 32'hBBBB_0001) begin errors++;
      $display("FAIL lru_fill440: got miss_hit=%h data=%h want 0/bbbb0001", r_miss_hit, r_post_load); end
    lookup(32'h440);
    checks++; if (r_hit !== 1'b1) begin errors++; $display("FAIL lru_reread440: got %h want 1", r_hit); end
    do_fill(32'h840, 32'hCCCC_0001, 32'hCCCC_0002, 0, 1'b1, 1'b0);
    checks++; if (r_miss_hit !== 1'b0 || r_post_load !== 32'hCCCC_0001) begin errors++;
      $display("FAIL lru_fill840: got miss_hit=%h data=%h want 0/cccc0001", r_miss_hit, r_post_load); end
    lookup(32'h444);
    checks++; if (r_hit !== 1'b1 || r_load !== 32'hBBBB_0002) begin errors++;
      $display("FAIL lru_keep440: got hit=%h data=%h want 1/bbbb0002", r_hit, r_load); end
    do_fill(32'h40, 32'hAAAA_0001, 32'hAAAA_0002, 0, 1'b1, 1'b0);
    checks++; if (r_miss_hit !== 1'b0) begin errors++; $display("FAIL lru_evicted040: got hit=%h want 0", r_miss_hit); end
    idle();
    checks++; if (hit_count !== 32'd7 || miss_count !== 32'd4) begin errors++;
      $display("FAIL lru_counters: got hit=%0d miss=%0d want 7/4", hit_count, miss_count); end
  endtask

  task automatic test_wait_states();
    do_fill(32'h100, 32'hDDDD_0001, 32'hDDDD_0002, 3, 1'b1, 1'b0);
    checks++; if (r_ren_cycles != 8) begin errors++; $display("FAIL wait_iren_cycles: got %0d want 8", r_ren_cycles); end
    checks++; if (r_addr_bad != 0) begin errors++; $display("FAIL wait_iaddr_stable: got %0d bad want 0", r_addr_bad); end
    checks++; if (r_hit_during != 0) begin errors++; $display("FAIL wait_no_hit: got %0d hits want 0", r_hit_during); end
    checks++; if (r_post_hit !== 1'b1 || r_post_load !== 32'hDDDD_0001) begin errors++;
      $display("FAIL wait_refetch: got hit=%h data=%h want 1/dddd0001", r_post_hit, r_post_load); end
    lookup(32'h104);
    checks++; if (r_hit !== 1'b1 || r_load !== 32'hDDDD_0002) begin errors++;
      $display("FAIL wait_word1: got hit=%h data=%h want 1/dddd0002", r_hit, r_load); end
  endtask

  task automatic test_blocking();
    @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h100; dmemREN = 1'b1;
    #1 checks++; if (ihit !== 1'b0 || imemload !== 32'h0) begin errors++;
      $display("FAIL block_dmemREN: got hit=%h data=%h want 0/0", ihit, imemload); end
    @(negedge CLK); dmemREN = 1'b0; dmemWEN = 1'b1;
    #1 checks++; if (ihit !== 1'b0 || imemload !== 32'h0) begin errors++;
      $display("FAIL block_dmemWEN: got hit=%h data=%h want 0/0", ihit, imemload); end
    @(negedge CLK); dmemWEN = 1'b0; halt = 1'b1;
    #1 checks++; if (ihit !== 1'b0 || imemload !== 32'h0) begin errors++;
      $display("FAIL block_halt: got hit=%h data=%h want 0/0", ihit, imemload); end
    idle();
    checks++; if (hit_count !== 32'd9 || miss_count !== 32'd5) begin errors++;
      $display("FAIL block_counters: got hit=%0d miss=%0d want 9/5", hit_count, miss_count); end
    lookup(32'h100);
    checks++; if (r_hit !== 1'b1 || r_load !== 32'hDDDD_0001) begin errors++;
      $display("FAIL block_release: got hit=%h data=%h want 1/dddd0001", r_hit, r_load); end
  endtask

  task automatic test_flush_fill();
    do_fill(32'h80, 32'hEEEE_0001, 32'hEEEE_0002, 0, 1'b0, 1'b1);
    checks++; if (r_post_ren !== 1'b0 || r_ren_cycles != 2) begin errors++;
      $display("FAIL flush_fill_done: got iREN=%h cycles=%0d want 0/2", r_post_ren, r_ren_cycles); end
    do_fill(32'h80, 32'hEEEE_0003, 32'hEEEE_0004, 0, 1'b1, 1'b0);
    checks++; if (r_miss_hit !== 1'b0) begin errors++; $display("FAIL flush_080_miss: got %h want 0", r_miss_hit); end
    checks++; if (r_post_load !== 32'hEEEE_0003) begin errors++;
      $display("FAIL flush_080_refill: got %h want eeee0003", r_post_load); end
    do_fill(32'h100, 32'hDDDD_0011, 32'hDDDD_0012, 0, 1'b1, 1'b0);
    checks++; if (r_miss_hit !== 1'b0) begin errors++; $display("FAIL flush_100_miss: got %h want 0", r_miss_hit); end
    idle();
    checks++; if (hit_count !== 32'd12 || miss_count !== 32'd8) begin errors++;
      $display("FAIL flush_counters: got hit=%0d miss=%0d want 12/8", hit_count, miss_count); end
  endtask

  task automatic test_reset_midfill();
    @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h200; iwait = 1'b0; iload = 32'hF000_0001;
    @(negedge CLK); iload = 32'hF000_0001;
    @(negedge CLK); iload = 32'hF000_0002; imemREN = 1'b0;
    #1 checks++; if (iREN !== 1'b1 || iaddr !== 32'h204) begin errors++;
      $display("FAIL rst_mid_beat1: got iREN=%h iaddr=%h want 1/00000204", iREN, iaddr); end
    #1 nRST = 1'b0;
    #1 checks++; if (iREN !== 1'b0 || iaddr !== 32'h0) begin errors++;
      $display("FAIL rst_mid_iren: got iREN=%h iaddr=%h want 0/0", iREN, iaddr); end
    checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin errors++;
      $display("FAIL rst_mid_counters: got hit=%0d miss=%0d want 0/0", hit_count, miss_count); end
    @(negedge CLK); nRST = 1'b1;
    do_fill(32'h100, 32'h1111_0001, 32'h1111_0002, 0, 1'b1, 1'b0);
    checks++; if (r_miss_hit !== 1'b0 || r_post_load !== 32'h1111_0001) begin errors++;
      $display("FAIL rst_mid_prior_miss: got miss_hit=%h data=%h want 0/11110001", r_miss_hit, r_post_load); end
    idle();
    checks++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin errors++;
      $display("FAIL rst_mid_post_counters: got hit=%0d miss=%0d want 1/1", hit_count, miss_count); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_lru();
    test_wait_states();
    test_blocking();
    test_flush_fill();
    test_reset_midfill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised, set-associative, multi-word-block instruction cache between the datapath fetch port and the memory controller's instruction channel.
- It is the next generation of the single-word direct-mapped icache.
- Adds configurable sets, ways and block size, LRU replacement, a sequential block-fill FSM, a flush input and hit/miss performance counters.
- Hits return instruction data combinationally in the same cycle.

Parameters:
- SETS, 8, number of sets; power of 2, ≥2.
- WAYS, 2, associativity; 1 or 2.
- WORDS, 2, 32-bit words per block; power of 2, ≥1.
- CNTW, 32, width of performance counters.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- halt  in  1  datapath halted; suppresses lookups.
- imemREN  in  1  fetch request.
- imemaddr  in  32  fetch byte address; word-aligned.
- dmemREN  in  1  data read pending; blocks new lookups.
- dmemWEN  in  1  data write pending; blocks new lookups.
- iflush  in  1  invalidate all lines.
- ihit  out  1  fetch complete this cycle.
- imemload  out  32  instruction word; valid when ihit.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iwait  in  1  memory not ready; iload valid when low with iREN high.
- iload  in  32  memory read data.
- hit_count  out  CNTW  lookups that hit.
- miss_count  out  CNTW  misses that started a fill.

Behaviour:
- Address split: [1:0] byte offset (ignored); next log2(WORDS) bits are the word offset; next log2(SETS) bits are the index; remaining upper bits are the tag.
- Storage per way per set: valid, tag and WORDS data words. Per set: one LRU bit when WAYS=2 (points to the victim way).
- Reset (async): all valid=0, LRU=0, FSM=IDLE, fill counter=0, both counters=0. Outputs at reset: ihit=0, imemload=0, iREN=0, iaddr=0.
- Lookup is active when FSM=IDLE && imemREN && !halt && !dmemREN && !dmemWEN.
  - On hit (valid && tag match in some way): ihit=1 and imemload=selected word, combinationally.
  - Edge: LRU[index] set to the other way; hit_count+1.
- Miss while lookup is active:
  - Same cycle: ihit=0.
  - Edge: FSM->FILL, latch block base (imemaddr with word offset and byte offset zeroed), select victim = first invalid way (way 0 preferred), else LRU way. Counter k=0; miss_count+1.
- FILL:
  - Drive iREN=1, iaddr=base+4*k.
  - Each cycle with iwait=0: write iload into victim word k; k+1.
  - On the last word (k=WORDS-1 with iwait=0): write tag, set valid=1, set LRU to the non-victim way, FSM->IDLE.
  - The re-presented fetch hits in the following cycle. Fill latency from miss = WORDS memory beats + 1 cycle.
- Outside FILL: iREN=0, iaddr=0.
- ihit=0 and imemload=0 whenever no hit is reported: during FILL, halt, dmem pending, or imemREN=0.
- A started fill always completes, even if imemaddr, imemREN, halt or dmem signals change mid-fill. Only nRST aborts it.
- iflush:
  - In IDLE: all valid cleared at the edge; a lookup in the same cycle still reports its result from pre-flush state.
  - In FILL: flush is applied at the edge where the fill completes, so the filled line is invalid too. Flush is held pending until then.
- WAYS=1: no LRU state; victim is always way 0.
- Counters wrap modulo 2^CNTW; no saturation.
- Refill of an already-valid victim overwrites data words as they arrive. Its tag is replaced only at the end of the fill. The old line must not hit during FILL, which holds because lookups are inactive in FILL.
- nRST asserted mid-fill: immediate return to reset state, iREN drops asynchronously.

Test Plan (SETS=8, WAYS=2, WORDS=2; index=addr[5:3], word=addr[2], tag=addr[31:6]):
1. Cold miss: fetch 0x0000_0040, memory returns 0xAAAA_0001/0xAAAA_0002 with iwait=0 -> iaddr 0x40 then 0x44, iREN 2 cycles, then ihit=1, imemload=0xAAAA_0001; fetch 0x44 hits immediately with 0xAAAA_0002; miss_count=1, hit_count=2.
2. Associativity/LRU: fill 0x040, 0x440, 0x840 (all index 0) with 0x440 re-read between fills -> 0x040 evicted; 0x440 still hits; 0x040 misses again.
3. Wait states: iwait=1 for 3 cycles per beat -> iaddr held stable while waiting; ihit only after both beats; exactly 2 data writes.
4. Blocking: hit address with dmemREN=1 -> ihit=0, imemload=0, counters unchanged; same for halt=1.
5. Flush during fill: iflush pulsed in beat 0 of a fill at 0x080 -> fill completes, then 0x080 and earlier-resident lines all miss.
6. Reset mid-fill: nRST low in beat 1 -> iREN=0 immediately, counters 0, prior hits now miss.
